// File: rtl/morph_window_sched.sv
// morph_window_sched
// Frame sequencer for the 3x3 morphological window kernels. It takes a
// raster pixel stream and keeps the two previous rows in line buffers. On
// every beat it drives the three row taps of one window column, plus a
// valid strobe. The top and bottom image borders are filled with PAD_VAL.
// One idle cycle is inserted between rows, and a done pulse marks the end
// of each frame.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_start      one-cycle frame start, ignored while busy
//   i_pix_valid  i_pix_data holds a valid pixel
//   i_pix_data   raster pixel, row-major
//   o_pix_ready  a pixel is consumed this cycle when i_pix_valid is high
//   o_row_top    window row above the center (kernel din1)
//   o_row_mid    center row (kernel din2)
//   o_row_bot    window row below the center (kernel din3)
//   o_win_valid  taps are valid this cycle (kernel valid_in)
//   o_busy       frame in progress
//   o_done       one-cycle pulse after the last window beat
module morph_window_sched #(
  parameter int             PIC_WIDTH  = 250,
  parameter int             PIC_HEIGHT = 250,
  parameter int             DW         = 8,
  parameter logic [DW-1:0]  PAD_VAL    = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_pix_valid,
  input  logic [DW-1:0] i_pix_data,
  output logic          o_pix_ready,
  output logic [DW-1:0] o_row_top,
  output logic [DW-1:0] o_row_mid,
  output logic [DW-1:0] o_row_bot,
  output logic          o_win_valid,
  output logic          o_busy,
  output logic          o_done
);

  localparam int CW = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
  localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_GAP, S_FLUSH, S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_col, w_col_next;
  logic [RW-1:0] r_row, w_row_next;

  logic [DW-1:0] r_row_top, r_row_mid, r_row_bot;
  logic          r_win_valid;
  logic          r_done;

  // lb0 holds row r-1 and lb1 holds row r-2, both indexed by column.
  logic [DW-1:0] r_lb0 [PIC_WIDTH];
  logic [DW-1:0] r_lb1 [PIC_WIDTH];
  logic [DW-1:0] w_lb0_rd, w_lb1_rd;

  logic          w_accept, w_col_last;
  logic          w_tap_load;
  logic [DW-1:0] w_top_next, w_mid_next, w_bot_next;
  logic          w_lb0_we, w_lb1_we;

  assign o_pix_ready = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_accept    = i_pix_valid && o_pix_ready;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_tap_load   = 1'b0;
    w_top_next   = w_lb1_rd;
    w_mid_next   = w_lb0_rd;
    w_bot_next   = i_pix_data;
    w_lb0_we     = 1'b0;
    w_lb1_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_FILL;
          w_col_next   = '0;
          w_row_next   = '0;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          w_lb0_we = 1'b1;
          if (w_col_last) begin
            w_col_next   = '0;
            w_row_next   = ROW_ONE;
            w_state_next = S_RUN;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_tap_load = 1'b1;
          // The first RUN row has no row above it, so the top tap is border.
          if (r_row == ROW_ONE) w_top_next = PAD_VAL;
          // Shift the column down one row: lb0 into lb1, new pixel into lb0.
          w_lb0_we = 1'b1;
          w_lb1_we = 1'b1;
          if (w_col_last) begin
            w_col_next   = '0;
            w_state_next = S_GAP;
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      S_GAP: begin
        // One idle cycle so the kernel's column counter can wrap.
        if (r_row == ROW_LAST) begin
          w_state_next = S_FLUSH;
        end else begin
          w_row_next   = r_row + 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_FLUSH: begin
        // Emit the last image row as center with a border row below it.
        // No input is needed here.
        w_tap_load = 1'b1;
        if (PIC_HEIGHT == 2) w_top_next = PAD_VAL;
        w_bot_next = PAD_VAL;
        if (w_col_last) begin
          w_col_next   = '0;
          w_state_next = S_DONE;
        end else begin
          w_col_next = r_col + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_row_top   <= '0;
      r_row_mid   <= '0;
      r_row_bot   <= '0;
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_win_valid <= w_tap_load;
      // The DONE cycle carries the last window beat. Registering the pulse
      // makes done land one cycle after that beat.
      r_done      <= (r_state == S_DONE);
      if (w_tap_load) begin
        r_row_top <= w_top_next;
        r_row_mid <= w_mid_next;
        r_row_bot <= w_bot_next;
      end
    end
  end

  // Line buffers are not reset: stale contents are always overwritten by
  // FILL and RUN before they are read. This keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_lb0_we) r_lb0[r_col] <= i_pix_data;
    if (w_lb1_we) r_lb1[r_col] <= w_lb0_rd;
  end

  assign o_row_top   = r_row_top;
  assign o_row_mid   = r_row_mid;
  assign o_row_bot   = r_row_bot;
  assign o_win_valid = r_win_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: doc/morph_window_sched.md
# morph_window_sched

Frame sequencer for the 3x3 morphological window kernels (erosion/dilation stages of the closing pipeline). It accepts a raster pixel stream, holds the two previous rows in internal line buffers, and drives the kernel's three row taps plus its valid strobe one window column per beat. It pads the top and bottom image borders with a programmable value, inserts the inter-row idle cycle the kernel's column counter needs, and signals frame completion.

## Interface
- PIC_WIDTH, 250: pixels per row (W); must be ≥2.
- PIC_HEIGHT, 250: rows per frame (H); must be ≥2.
- DW, 8: pixel width in bits.
- PAD_VAL, {DW{1'b1}}: border row value. All-ones for erosion, 0 for dilation.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start; ignored while busy.
- pix_valid  in  1  pix_data valid.
- pix_data  in  DW  raster pixel, row-major.
- pix_ready  out  1  block accepts a pixel this cycle.
- row_top  out  DW  window row above center (kernel din1).
- row_mid  out  DW  center row (kernel din2).
- row_bot  out  DW  row below center (kernel din3).
- win_valid  out  1  taps valid this cycle (kernel valid_in).
- busy  out  1  frame in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse at frame end.

## Operation
- Accept = pix_valid && pix_ready. pix_ready is decoded from the state register: 1 in FILL and RUN, 0 in all other states.
- Counters: col runs 0..W-1 and row runs 0..H-1, each $clog2-sized.
- Line buffers: lb0[W] holds row r-1 and lb1[W] holds row r-2, both DW wide.
- States:
  - IDLE: on start, go to FILL with col=row=0.
  - FILL: on each accept, lb0[col] <= pix. No output. At col=W-1, go to RUN with row=1.
  - RUN: on each accept:
    - row_top <= (row==1) ? PAD_VAL : lb1[col]
    - row_mid <= lb0[col]
    - row_bot <= pix
    - lb1[col] <= lb0[col]; lb0[col] <= pix
    - win_valid <= 1
    - At col=W-1, go to GAP.
  - GAP: exactly one cycle. pix_ready=0, win_valid=0. Next state is FLUSH if row==H-1, otherwise RUN with row+1.
  - FLUSH: W internal beats, one per cycle, no input needed.
    - row_top <= (H==2) ? PAD_VAL : lb1[col]
    - row_mid <= lb0[col]
    - row_bot <= PAD_VAL
    - win_valid <= 1
    - After col=W-1, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- win_valid is 0 in every cycle without a RUN accept or a FLUSH beat. Taps hold their last values when win_valid=0.
- Pixels presented while pix_ready=0 are not consumed. The source must hold them.
- start while busy has no effect.
- rst_n assertion mid-frame: immediate return to IDLE with all outputs at reset values. Line buffer contents are don't-care; the next frame after start is fully correct.

## Timing
- Reset values: pix_ready=0, row_top=row_mid=row_bot=0, win_valid=0, busy=0, done=0.
- Taps and win_valid are registered and appear 1 cycle after the accept (RUN) or beat (FLUSH).
- With continuous pix_valid, frame length from start is 1 + H·W input cycles + (H-1) gap cycles + W flush cycles + 1 DONE cycle.
- done is high in the cycle after the last win_valid.
- Exactly H·W win_valid beats occur per frame.
- Input stalls (pix_valid=0) freeze col, row and state. win_valid is 0 during stalls.

## Test plan
- **Reset:** assert rst_n=0 with random inputs. All outputs must be 0 and busy=0. After release with no start, pix_ready stays 0.
- **Ramp frame:** W=4, H=3, DW=8, PAD_VAL=FF, pix=row·16+col, continuous valid.
  - First win_valid is 1 cycle after pixel 0x10 is accepted, with taps (FF,00,10).
  - Row-2 beats give (00,10,20)..(03,13,23).
  - Flush gives (10,20,FF)..(13,23,FF).
  - 12 beats total; done pulses the cycle after (13,23,FF).
- **Gaps:** same frame with pix_valid toggled pseudo-randomly. The tap sequence must be identical to the ramp frame and no win_valid may occur during stalls.
- **Ready gating:** pix_ready=0 exactly 1 cycle between RUN rows and throughout FLUSH. A pixel held there is accepted only when RUN resumes.
- **Control abuse:** pulse start mid-RUN; there must be no effect. Assert rst_n=0 mid-RUN, restart the frame, and the output must match the ramp frame exactly.
- **Dilation pad, minimum height:** PAD_VAL=00, H=2, W=4. Row-1 beats give (00,r0,r1). Flush beats give (00,r1,00).
